lsu_mem_master: RTL and testbench

- Load/store initiator between the single-cycle core's execute stage and a word-organised data memory with a request/grant port.
- Turns a core access (funct3-typed byte/half/word, signed/unsigned) into word-aligned memory transactions with byte enables.
- Extends load data and returns a single response per request.
- One request outstanding at a time; the core stalls on req_ready low.

---
 rtl/lsu_mem_master.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the core execute stage and a
// word-organised data memory with a request/grant port. Converts a funct3-typed
// access into word-aligned transactions with byte enables and returns one
// extended response per request. One request is outstanding at a time.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When defined, accesses that
// cross a word boundary are split into two memory transactions. When undefined,
// they complete with an error and no memory traffic.
module lsu_mem_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC0  = 3'd1,
    WAIT0 = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    ACC1  = 3'd3,
    WAIT1 = 3'd4,
`endif
    RESP  = 3'd5
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Unshifted byte mask for a funct3 size code (byte, half, word).
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Sign- or zero-extend the right-aligned load word according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'h00_0000, w[7:0]};
      3'b101:  r = {16'h0000, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-3:0] waddr_q, waddr_d;
  logic [1:0]            off_q, off_d;
  logic                  err_q, err_d;
  logic [3:0]            be_lo_q, be_lo_d;
  logic [31:0]           wd_lo_q, wd_lo_d;
  logic [31:0]           lo_q, lo_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic                  cross_q, cross_d;
  logic [3:0]            be_hi_q, be_hi_d;
  logic [31:0]           wd_hi_q, wd_hi_d;
  logic [31:0]           hi_q, hi_d;
  logic [7:0]            be8_s;
  logic [63:0]           wd64_s;
  logic [3:0]            be_hi_s;
  logic [31:0]           wd_hi_s;
`endif

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [1:0]            off_s;
  logic                  illegal_s;
  logic                  cross_s;
  logic [3:0]            be_lo_s;
  logic [31:0]           wd_lo_s;
  logic [31:0]           rd_word_s;

  // Decode the incoming request: legality, word crossing, lane mask and data.
  always_comb begin
    off_s   = req_addr[1:0];
    cross_s = ((req_funct3[1:0] == 2'b01) && (off_s == 2'b11)) ||
              ((req_funct3[1:0] == 2'b10) && (off_s != 2'b00));
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = req_we;
      default:                illegal_s = 1'b1;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    be8_s   = {4'b0000, size_mask(req_funct3[1:0])} << off_s;
    wd64_s  = {32'h0000_0000, req_wdata} << {off_s, 3'b000};
    be_lo_s = be8_s[3:0];
    be_hi_s = be8_s[7:4];
    wd_lo_s = wd64_s[31:0];
    wd_hi_s = wd64_s[63:32];
`else
    be_lo_s = size_mask(req_funct3[1:0]) << off_s;
    wd_lo_s = req_wdata << {off_s, 3'b000};
`endif
  end

  // Next-state logic: request latching, FSM transitions and read-data capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    err_d   = err_q;
    be_lo_d = be_lo_q;
    wd_lo_d = wd_lo_q;
    lo_d    = lo_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    cross_d = cross_q;
    be_hi_d = be_hi_q;
    wd_hi_d = wd_hi_q;
    hi_d    = hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          waddr_d = req_addr[ADDR_WIDTH-1:2];
          off_d   = off_s;
          be_lo_d = be_lo_s;
          wd_lo_d = wd_lo_s;
`ifdef LSU_MISALIGN_SPLIT_EN
          cross_d = cross_s;
          be_hi_d = be_hi_s;
          wd_hi_d = wd_hi_s;
          err_d   = illegal_s;
`else
          err_d   = illegal_s || cross_s;
`endif
          state_d = (err_d) ? RESP : ACC0;
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        if (mem_gnt) begin
          if (we_q) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = (cross_q) ? ACC1 : RESP;
`else
            state_d = RESP;
`endif
          end else begin
            state_d = WAIT0;
          end
        end else begin
          state_d = ACC0;
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          lo_d    = mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = (cross_q) ? ACC1 : RESP;
`else
          state_d = RESP;
`endif
        end else begin
          state_d = WAIT0;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        if (mem_gnt) begin
          state_d = (we_q) ? RESP : WAIT1;
        end else begin
          state_d = ACC1;
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          hi_d    = mem_rdata;
          state_d = RESP;
        end else begin
          state_d = WAIT1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pick the requested bytes out of the buffered read word(s).
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    rd_word_s = 32'({hi_d, lo_d} >> {off_d, 3'b000});
`else
    rd_word_s = lo_d >> {off_d, 3'b000};
`endif
  end

  // Output values for the coming cycle, derived from the next state so every
  // port is driven straight from a flop.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && err_d;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {ADDR_WIDTH{1'b0}};
    mem_be_d    = 4'b0000;
    mem_wdata_d = 32'h0000_0000;
    if (state_d == RESP) begin
      if (err_d) begin
        rsp_rdata_d = ERR_DATA;
      end else if (we_d) begin
        rsp_rdata_d = 32'h0000_0000;
      end else begin
        rsp_rdata_d = load_extend(f3_d, rd_word_s);
      end
    end else begin
      rsp_rdata_d = 32'h0000_0000;
    end
    case (state_d)
      ACC0: begin
        mem_req_d   = 1'b1;
        mem_we_d    = we_d;
        mem_addr_d  = {waddr_d, 2'b00};
        mem_be_d    = be_lo_d;
        mem_wdata_d = wd_lo_d;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        mem_req_d   = 1'b1;
        mem_we_d    = we_d;
        mem_addr_d  = {waddr_d + {{(ADDR_WIDTH-3){1'b0}}, 1'b1}, 2'b00};
        mem_be_d    = be_hi_d;
        mem_wdata_d = wd_hi_d;
      end
`endif
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, request context and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      waddr_q     <= {(ADDR_WIDTH-2){1'b0}};
      off_q       <= 2'b00;
      err_q       <= 1'b0;
      be_lo_q     <= 4'b0000;
      wd_lo_q     <= 32'h0000_0000;
      lo_q        <= 32'h0000_0000;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q     <= 1'b0;
      be_hi_q     <= 4'b0000;
      wd_hi_q     <= 32'h0000_0000;
      hi_q        <= 32'h0000_0000;
`endif
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      waddr_q     <= waddr_d;
      off_q       <= off_d;
      err_q       <= err_d;
      be_lo_q     <= be_lo_d;
      wd_lo_q     <= wd_lo_d;
      lo_q        <= lo_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q     <= cross_d;
      be_hi_q     <= be_hi_d;
      wd_hi_q     <= wd_hi_d;
      hi_q        <= hi_d;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master. The bench plays the data
// memory (grant delay, read latency, byte-enabled writes) and compares every
// transaction against hand-computed values.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] mem_arr [0:63];
  int total = 0;
  int bad   = 0;

  // Observations of the last transaction
  int          n_acc, n_rsp, rsp_lat, n_req_cyc;
  logic [31:0] acc_addr [2];
  logic [31:0] acc_wd   [2];
  logic [3:0]  acc_be   [2];
  logic        acc_we   [2];
  logic [31:0] rsp_data;
  logic        rsp_e;
  logic        stable_bad, ready_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one request and act as the memory until the response has passed.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gnt_wait, input int rv_wait);
    int held, rv_cnt, rv_idx, cyc, wi;
    logic [31:0] p_addr, p_wd;
    logic [3:0]  p_be;
    n_acc = 0; n_rsp = 0; rsp_lat = -1; n_req_cyc = 0;
    rsp_data = 32'h0; rsp_e = 1'b0; stable_bad = 1'b0; ready_bad = 1'b0;
    p_addr = 32'h0; p_wd = 32'h0; p_be = 4'h0; rv_idx = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; held = 0; rv_cnt = -1;
    for (int c = 0; c < 40; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_arr[rv_idx];
          rv_cnt     = -1;
        end
      end
      if (rsp_valid) begin
        if (n_rsp == 0) begin
          rsp_lat = cyc; rsp_data = rsp_rdata; rsp_e = rsp_err;
        end
        n_rsp++;
      end
      if (req_ready && (n_rsp == 0 || rsp_valid)) ready_bad = 1'b1;
      if (n_rsp > 0 && cyc == rsp_lat + 1 && !req_ready) ready_bad = 1'b1;
      if (mem_req) begin
        n_req_cyc++;
        if (held > 0 && (mem_addr !== p_addr || mem_be !== p_be || mem_wdata !== p_wd))
          stable_bad = 1'b1;
        p_addr = mem_addr; p_be = mem_be; p_wd = mem_wdata;
        if (held >= gnt_wait) begin
          mem_gnt = 1'b1;
          if (n_acc < 2) begin
            acc_addr[n_acc] = mem_addr; acc_be[n_acc] = mem_be;
            acc_wd[n_acc] = mem_wdata; acc_we[n_acc] = mem_we;
          end
          n_acc++;
          wi = int'(mem_addr[7:2]);
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem_arr[wi][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            rv_cnt = rv_wait; rv_idx = wi;
          end
          held = 0;
        end else begin
          held++;
        end
      end
      if (n_rsp > 0 && cyc >= rsp_lat + 2) break;
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Common response checks for a load.
  task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input int rv_wait, input logic [31:0] exp);
    run_req(1'b0, f3, addr, 32'h0, 0, rv_wait);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_err"}, 32'(rsp_e), 32'd0);
    check({tag, "_npulse"}, 32'(n_rsp), 32'd1);
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_arr[0] = 32'h4433_2211;
    mem_arr[1] = 32'h8877_6655;
    mem_arr[8] = 32'h80F0_7F01;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_rspvalid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_be", 32'(mem_be), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    // Aligned word store, immediate grant
    run_req(1'b1, 3'b010, 32'h10, 32'h1234_5678, 0, 1);
    check("sw_nacc", 32'(n_acc), 32'd1);
    check("sw_addr", acc_addr[0], 32'h10);
    check("sw_be", 32'(acc_be[0]), 32'hF);
    check("sw_wdata", acc_wd[0], 32'h1234_5678);
    check("sw_we", 32'(acc_we[0]), 32'd1);
    check("sw_lat", 32'(rsp_lat), 32'd2);
    check("sw_err", 32'(rsp_e), 32'd0);
    check("sw_rdata", rsp_data, 32'h0);
    check("sw_reqcyc", 32'(n_req_cyc), 32'd1);
    check("sw_ready", 32'(ready_bad), 32'd0);

    // Sub-word stores
    run_req(1'b1, 3'b000, 32'h13, 32'h0000_00AB, 0, 1);
    check("sb_addr", acc_addr[0], 32'h10);
    check("sb_be", 32'(acc_be[0]), 32'h8);
    check("sb_wd", {24'h0, acc_wd[0][31:24]}, 32'hAB);
    run_req(1'b1, 3'b001, 32'h16, 32'h0000_BEEF, 0, 1);
    check("sh_addr", acc_addr[0], 32'h14);
    check("sh_be", 32'(acc_be[0]), 32'hC);
    check("sh_wd", acc_wd[0], 32'hBEEF_0000);
    check("sh_mem", mem_arr[5], 32'hBEEF_0000);

    // Loads with extension from word 0x80F07F01
    check_load("lb21", 3'b000, 32'h21, 1, 32'h0000_007F);
    check("lb21_addr", acc_addr[0], 32'h20);
    check("lb21_we", 32'(acc_we[0]), 32'd0);
    check_load("lb23", 3'b000, 32'h23, 2, 32'hFFFF_FF80);
    check_load("lbu23", 3'b100, 32'h23, 1, 32'h0000_0080);
    check_load("lh22", 3'b001, 32'h22, 3, 32'hFFFF_80F0);
    check_load("lhu22", 3'b101, 32'h22, 1, 32'h0000_80F0);
    check_load("lw20", 3'b010, 32'h20, 1, 32'h80F0_7F01);
    check_load("lh21", 3'b001, 32'h21, 1, 32'hFFFF_F07F);
    check("lh21_be", 32'(acc_be[0]), 32'h6);
    check_load("lb10", 3'b000, 32'h13, 1, 32'hFFFF_FFAB);

    // Back-pressure: grant withheld 3 cycles, read data 2 cycles after grant
    run_req(1'b0, 3'b010, 32'h20, 32'h0, 3, 2);
    check("bp_data", rsp_data, 32'h80F0_7F01);
    check("bp_stable", 32'(stable_bad), 32'd0);
    check("bp_ready", 32'(ready_bad), 32'd0);
    check("bp_npulse", 32'(n_rsp), 32'd1);
    check("bp_reqcyc", 32'(n_req_cyc), 32'd4);
    check("bp_lat", 32'(rsp_lat), 32'd7);

    // Illegal funct3 on load and store
    run_req(1'b0, 3'b011, 32'h20, 32'h0, 0, 1);
    check("ill_ld_err", 32'(rsp_e), 32'd1);
    check("ill_ld_data", rsp_data, 32'hDEAD_BEEF);
    check("ill_ld_req", 32'(n_req_cyc), 32'd0);
    check("ill_ld_lat", 32'(rsp_lat), 32'd1);
    run_req(1'b1, 3'b100, 32'h20, 32'h0, 0, 1);
    check("ill_st_err", 32'(rsp_e), 32'd1);
    check("ill_st_req", 32'(n_req_cyc), 32'd0);

    // Reset while waiting for read data; late rvalid must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_acc0_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rw_wait_req", 32'(mem_req), 32'd0);
    check("rw_wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rw_idle_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) pulses++;
    end
    check("rw_no_rsp", 32'(pulses), 32'd0);
    check("rw_still_idle", 32'(req_ready), 32'd1);

    // Word-crossing accesses
    run_req(1'b0, 3'b010, 32'h2, 32'h0, 0, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("xlw_nacc", 32'(n_acc), 32'd2);
    check("xlw_a0", acc_addr[0], 32'h0);
    check("xlw_a1", acc_addr[1], 32'h4);
    check("xlw_data", rsp_data, 32'h6655_4433);
    check("xlw_err", 32'(rsp_e), 32'd0);
`else
    check("xlw_err", 32'(rsp_e), 32'd1);
    check("xlw_data", rsp_data, 32'hDEAD_BEEF);
    check("xlw_req", 32'(n_req_cyc), 32'd0);
`endif
    run_req(1'b1, 3'b010, 32'h3, 32'hAABB_CCDD, 0, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("xsw_nacc", 32'(n_acc), 32'd2);
    check("xsw_be0", 32'(acc_be[0]), 32'h8);
    check("xsw_be1", 32'(acc_be[1]), 32'h7);
    check("xsw_wd0", acc_wd[0], 32'hDD00_0000);
    check("xsw_wd1", acc_wd[1], 32'h00AA_BBCC);
    check("xsw_a1", acc_addr[1], 32'h4);
    check("xsw_err", 32'(rsp_e), 32'd0);
`else
    check("xsw_err", 32'(rsp_e), 32'd1);
    check("xsw_data", rsp_data, 32'hDEAD_BEEF);
    check("xsw_req", 32'(n_req_cyc), 32'd0);
`endif
    run_req(1'b0, 3'b000, 32'h3, 32'h0, 0, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("lb3_data", rsp_data, 32'hFFFF_FFDD);
`else
    check("lb3_data", rsp_data, 32'h0000_0044);
`endif
    check("lb3_err", 32'(rsp_e), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
